wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter WordLen, default 32, meaning the width of the write-back data.
REQ-002 SHALL have parameter WordCount, default 15, meaning the number of register-file entries; AW = $clog2(WordCount).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports a_valid/b_valid, input, 1 bit each: requester A (ALU write-back) and requester B (load return) hold a write request.
REQ-006 SHALL have ports a_dest/b_dest, input, AW bits each: target register index.
REQ-007 SHALL have ports a_data/b_data, input, WordLen bits each: write data.
REQ-008 SHALL have ports a_ready/b_ready, output, 1 bit each: combinational grant; a transfer occurs on a rising edge where valid&&ready.
REQ-009 SHALL have port clr_start, input, 1 bit: one-cycle pulse requesting a clear sweep of all registers.
REQ-010 SHALL have port clr_busy, output, 1 bit: sweep in progress.
REQ-011 SHALL have port clr_done, output, 1 bit: one-cycle pulse after the last clear is issued.
REQ-012 SHALL have ports wb_en/wb_sclr, output, 1 bit each: registered write-enable and synchronous-clear to the register file.
REQ-013 SHALL have port wb_dest, output, AW bits: registered register-file index.
REQ-014 SHALL have port wb_data, output, WordLen bits: registered register-file write data.
REQ-015 SHALL have port dest_err, output, 1 bit: sticky flag, set when an accepted request has dest >= WordCount.

Function
REQ-016 SHALL implement FSM states IDLE and SWEEP.
REQ-017 In IDLE with clr_start=1, both readies SHALL be 0; the next edge SHALL enter SWEEP with sweep counter = 0.
REQ-018 In IDLE without clr_start: one valid -> that requester ready; both valid -> round-robin pointer selects; none valid -> both ready 0.
REQ-019 Round-robin pointer SHALL toggle to the other requester only when both were valid and a grant occurred; a single requester SHALL never be stalled.
REQ-020 Accepted request at edge N SHALL drive wb_en=1, wb_dest, and wb_data from edge N to edge N+1 (one cycle latency), stable for the register file's falling-edge capture.
REQ-021 When no transfer occurs, wb_en and wb_sclr SHALL be 0 the following cycle; wb_dest and wb_data SHALL hold their last values.
REQ-022 Accepted request with dest >= WordCount SHALL produce wb_en=0 (write dropped) and set dest_err until reset.
REQ-023 In SWEEP, both readies SHALL be 0; each cycle SHALL drive wb_sclr=1, wb_en=0, wb_dest=counter, and counter SHALL increment.
REQ-024 When counter = WordCount-1 is issued, the next edge SHALL return to IDLE and assert clr_done for exactly one cycle.
REQ-025 clr_busy SHALL be 1 exactly while the state is SWEEP (WordCount cycles).
REQ-026 clr_start while in SWEEP SHALL be ignored; it is not queued.
REQ-027 wb_en and wb_sclr SHALL never be 1 in the same cycle.

Reset
REQ-028 rst=1 SHALL asynchronously force: IDLE, counter=0, pointer=A, wb_en=0, wb_sclr=0, wb_dest=0, wb_data=0, clr_busy=0, clr_done=0, dest_err=0.
REQ-029 rst asserted mid-sweep SHALL abort the sweep without a clr_done pulse; partially cleared registers are not restored by this block.
REQ-030 While rst=1, a_ready and b_ready SHALL be 0.

Verification
REQ-031 Only A is valid, dest=3, data=0xDEADBEEF -> a_ready=1; the next cycle shows wb_en=1, wb_dest=3, wb_data=0xDEADBEEF.
REQ-032 A and B are both held valid for 4 cycles after reset -> grants go A,B,A,B and wb_data alternates accordingly.
REQ-033 clr_start pulse, with A valid throughout -> a_ready=0 for 16 cycles (the start cycle plus 15 sweep cycles); wb_sclr=1 with wb_dest running 0..14; clr_done pulses once; A is then granted.
REQ-034 B is valid with dest=15 -> accepted, wb_en stays 0, and dest_err=1 persists until rst.
REQ-035 rst asserted when sweep counter = 7 -> all outputs are immediately 0, no clr_done, and the FSM is in IDLE after release.
REQ-036 clr_start is re-pulsed while clr_busy=1 -> the sweep length remains exactly 15 cycles with one clr_done.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Two-requester write-back port arbiter for a register file, with a
// sequential clear sweep that issues one synchronous clear per cycle.
module wb_port_arbiter #(
  parameter int WordLen   = 32,
  parameter int WordCount = 15,
  localparam int AW = (WordCount > 1) ? $clog2(WordCount) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  input  logic [AW-1:0]      a_dest,
  input  logic [WordLen-1:0] a_data,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [AW-1:0]      b_dest,
  input  logic [WordLen-1:0] b_data,
  output logic               b_ready,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic               clr_done,
  output logic               wb_en,
  output logic               wb_sclr,
  output logic [AW-1:0]      wb_dest,
  output logic [WordLen-1:0] wb_data,
  output logic               dest_err
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [AW:0]   WC_EXT = (AW+1)'(WordCount);
  localparam logic [AW-1:0] LAST   = AW'(WordCount - 1);

  state_t       state;
  logic [AW-1:0] cnt;
  logic          ptr;   // 0: A wins a tie, 1: B wins a tie
  logic          grant_a;
  logic          grant_b;
  logic [AW-1:0] sel_dest;
  logic [WordLen-1:0] sel_data;
  logic          dest_ok;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst && state == IDLE && !clr_start) begin
      if (a_valid && b_valid) begin
        a_ready = ~ptr;
        b_ready = ptr;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  assign grant_a  = a_valid && a_ready;
  assign grant_b  = b_valid && b_ready;
  assign sel_dest = grant_b ? b_dest : a_dest;
  assign sel_data = grant_b ? b_data : a_data;
  assign dest_ok  = ({1'b0, sel_dest} < WC_EXT);
  assign clr_busy = (state == SWEEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= 1'b0;
      wb_en    <= 1'b0;
      wb_sclr  <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
      clr_done <= 1'b0;
      dest_err <= 1'b0;
    end else begin
      wb_en    <= 1'b0;
      wb_sclr  <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state <= SWEEP;
            cnt   <= '0;
          end else if (grant_a || grant_b) begin
            // out-of-range writes are dropped; only the sticky flag records them
            if (dest_ok) begin
              wb_en   <= 1'b1;
              wb_dest <= sel_dest;
              wb_data <= sel_data;
            end else begin
              dest_err <= 1'b1;
            end
            if (a_valid && b_valid) ptr <= ~ptr;
          end
        end
        SWEEP: begin
          wb_sclr <= 1'b1;
          wb_dest <= cnt;
          if (cnt == LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
      endcase
    end
  end

endmodule
